// File: rtl/cnn_window_gen.sv
// Sliding KY x KX window generator for a streamed raster image (valid padding).
// Emits one packed window per interior pixel plus a frame-done pulse.
module cnn_window_gen #(
  parameter int CI     = 4,
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int IW     = 8,
  parameter int IH     = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          soft_reset_i,
  input  logic                          in_valid_i,
  input  logic [CI*I_F_BW-1:0]          in_pixel_i,
  output logic                          ot_valid_o,
  output logic [CI*KX*KY*I_F_BW-1:0]    ot_fmap_o,
  output logic                          ot_frame_done_o
);

  localparam int PW = CI * I_F_BW;
  localparam int FW = CI * KX * KY * I_F_BW;
  localparam int LB = (KY > 1) ? KY - 1 : 1;
  localparam int CW = (IW > 1) ? $clog2(IW) : 1;
  localparam int RW = (IH > 1) ? $clog2(IH) : 1;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_valid;
  logic          r_frame_done;
  logic [FW-1:0] r_fmap;
  logic [PW-1:0] r_win [KY][KX];
  logic [PW-1:0] r_lb  [LB][IW];

  logic          w_accept;
  logic          w_last_col;
  logic          w_last_row;
  logic          w_row_ok;
  logic          w_col_ok;
  logic [PW-1:0] w_col_pix  [KY];
  logic [PW-1:0] w_win_next [KY][KX];
  logic [FW-1:0] w_fmap_next;

  // Soft reset wins over a simultaneous pixel, which is dropped.
  assign w_accept   = in_valid_i & ~soft_reset_i;
  assign w_last_col = (r_col == CW'(IW - 1));
  assign w_last_row = (r_row == RW'(IH - 1));

  if (KY > 1) begin : g_row_ok
    assign w_row_ok = (r_row >= RW'(KY - 1));
  end else begin : g_row_any
    assign w_row_ok = 1'b1;
  end

  if (KX > 1) begin : g_col_ok
    assign w_col_ok = (r_col >= CW'(KX - 1));
  end else begin : g_col_any
    assign w_col_ok = 1'b1;
  end

  // Vertical column entering the window: older rows from line buffers, newest is the live pixel.
  for (genvar gi = 0; gi < KY; gi++) begin : g_col
    if (gi == KY - 1) begin : g_live
      assign w_col_pix[gi] = in_pixel_i;
    end else begin : g_buf
      assign w_col_pix[gi] = r_lb[gi][r_col];
    end
  end

  for (genvar gi = 0; gi < KY; gi++) begin : g_wy
    for (genvar gx = 0; gx < KX; gx++) begin : g_wx
      if (gx == KX - 1) begin : g_new
        assign w_win_next[gi][gx] = w_col_pix[gi];
      end else begin : g_shift
        assign w_win_next[gi][gx] = r_win[gi][gx+1];
      end
    end
  end

  for (genvar gc = 0; gc < CI; gc++) begin : g_pc
    for (genvar gi = 0; gi < KY; gi++) begin : g_py
      for (genvar gx = 0; gx < KX; gx++) begin : g_px
        assign w_fmap_next[((gc*KY+gi)*KX+gx)*I_F_BW +: I_F_BW] =
          w_win_next[gi][gx][gc*I_F_BW +: I_F_BW];
      end
    end
  end

  // Line buffers carry no reset; each row slot moves up one buffer per accepted pixel.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < KY - 1; k++) begin
        r_lb[k][r_col] <= w_col_pix[k+1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_fmap       <= '0;
      for (int y = 0; y < KY; y++)
        for (int x = 0; x < KX; x++)
          r_win[y][x] <= '0;
    end else if (soft_reset_i) begin
      r_col        <= '0;
      r_row        <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_fmap       <= '0;
      for (int y = 0; y < KY; y++)
        for (int x = 0; x < KX; x++)
          r_win[y][x] <= '0;
    end else begin
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_accept) begin
        for (int y = 0; y < KY; y++)
          for (int x = 0; x < KX; x++)
            r_win[y][x] <= w_win_next[y][x];
        if (w_row_ok && w_col_ok) begin
          r_valid <= 1'b1;
          r_fmap  <= w_fmap_next;
        end
        r_frame_done <= w_last_row & w_last_col;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  assign ot_valid_o      = r_valid;
  assign ot_fmap_o       = r_fmap;
  assign ot_frame_done_o = r_frame_done;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Bench for cnn_window_gen: scenario tasks checked against an image-array window model.
// Small 4x4 image, 3x3 kernel, two channels (channel 1 = channel 0 + 50 in directed tests).
module tb_cnn_window_gen;
  localparam int CI = 2, KX = 3, KY = 3, BW = 8, IW = 4, IH = 4;
  localparam int PW = CI * BW;
  localparam int FW = CI * KX * KY * BW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          soft_reset_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic [PW-1:0] in_pixel_i = '0;
  logic          ot_valid_o;
  logic [FW-1:0] ot_fmap_o;
  logic          ot_frame_done_o;

  cnn_window_gen #(.CI(CI), .KX(KX), .KY(KY), .I_F_BW(BW), .IW(IW), .IH(IH)) dut (
    .clk(clk), .reset_n(reset_n), .soft_reset_i(soft_reset_i),
    .in_valid_i(in_valid_i), .in_pixel_i(in_pixel_i),
    .ot_valid_o(ot_valid_o), .ot_fmap_o(ot_fmap_o), .ot_frame_done_o(ot_frame_done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the frame image as written so far plus the raster position.
  logic [PW-1:0] img [IH][IW];
  int            m_row = 0, m_col = 0;
  logic          exp_valid = 1'b0, exp_done = 1'b0;
  logic [FW-1:0] exp_fmap = '0;
  int            dut_wins, dut_dones;
  logic [FW-1:0] dut_first, dut_last;

  function automatic logic [PW-1:0] px(input int v0, input int v1);
    logic [7:0] a, b;
    a = v0[7:0];
    b = v1[7:0];
    return {b, a};
  endfunction

  // Window whose top-left pixel has value base in a 4-wide ramp image; channel 1 adds 50.
  function automatic logic [FW-1:0] spec_win(input int base);
    logic [FW-1:0] w;
    int v;
    w = '0;
    for (int ky = 0; ky < KY; ky++)
      for (int kx = 0; kx < KX; kx++) begin
        v = base + 4 * ky + kx;
        w[((0*KY+ky)*KX+kx)*BW +: BW] = v[7:0];
        v = v + 50;
        w[((1*KY+ky)*KX+kx)*BW +: BW] = v[7:0];
      end
    return w;
  endfunction

  task automatic step(input bit v, input bit srst, input logic [PW-1:0] pix);
    @(negedge clk);
    in_valid_i   = v;
    soft_reset_i = srst;
    in_pixel_i   = pix;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (srst) begin
      m_row = 0; m_col = 0; exp_fmap = '0;
    end else if (v) begin
      img[m_row][m_col] = pix;
      if (m_row >= KY - 1 && m_col >= KX - 1) begin
        exp_valid = 1'b1;
        for (int c = 0; c < CI; c++)
          for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
              exp_fmap[((c*KY+ky)*KX+kx)*BW +: BW] =
                img[m_row-KY+1+ky][m_col-KX+1+kx][c*BW +: BW];
        $display("window at r=%0d c=%0d fmap=%h", m_row, m_col, exp_fmap);
      end
      exp_done = (m_row == IH - 1) && (m_col == IW - 1);
      if (m_col == IW - 1) begin
        m_col = 0;
        m_row = (m_row == IH - 1) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
    if (ot_valid_o === 1'b1) begin
      dut_wins++;
      if (dut_wins == 1) dut_first = ot_fmap_o;
      dut_last = ot_fmap_o;
    end
    if (ot_frame_done_o === 1'b1) dut_dones++;
  endtask

  task automatic clear_stats();
    dut_wins = 0; dut_dones = 0; dut_first = '0; dut_last = '0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ot_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ot_valid_o); end
    checks++; if (ot_frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", ot_frame_done_o); end
    checks++; if (ot_fmap_o !== '0) begin errors++; $display("FAIL reset_fmap got %h want 0", ot_fmap_o); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    clear_stats();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, px(i, i + 50));
      checks++;
      if (ot_valid_o !== exp_valid || ot_frame_done_o !== exp_done || ot_fmap_o !== exp_fmap) begin
        errors++;
        $display("FAIL basic px%0d got v=%b d=%b f=%h want v=%b d=%b f=%h", i,
                 ot_valid_o, ot_frame_done_o, ot_fmap_o, exp_valid, exp_done, exp_fmap);
      end
    end
    checks++; if (dut_wins != 4) begin errors++; $display("FAIL basic_count got %0d want 4", dut_wins); end
    checks++; if (dut_dones != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", dut_dones); end
    checks++; if (dut_first !== spec_win(0)) begin errors++; $display("FAIL basic_first got %h want %h", dut_first, spec_win(0)); end
    checks++; if (dut_last !== spec_win(5)) begin errors++; $display("FAIL basic_last got %h want %h", dut_last, spec_win(5)); end
  endtask

  task automatic test_gaps();
    int i;
    clear_stats();
    i = 0;
    for (int s = 0; s < 48; s++) begin
      if (s % 3 == 0) begin
        step(1'b1, 1'b0, px(i, i + 50));
        i++;
      end else begin
        step(1'b0, 1'b0, px(255, 255));
      end
      checks++;
      if (ot_valid_o !== exp_valid || ot_frame_done_o !== exp_done || ot_fmap_o !== exp_fmap) begin
        errors++;
        $display("FAIL gaps step%0d got v=%b d=%b f=%h want v=%b d=%b f=%h", s,
                 ot_valid_o, ot_frame_done_o, ot_fmap_o, exp_valid, exp_done, exp_fmap);
      end
    end
    checks++; if (dut_wins != 4) begin errors++; $display("FAIL gaps_count got %0d want 4", dut_wins); end
    checks++; if (dut_first !== spec_win(0)) begin errors++; $display("FAIL gaps_first got %h want %h", dut_first, spec_win(0)); end
    checks++; if (dut_last !== spec_win(5)) begin errors++; $display("FAIL gaps_last got %h want %h", dut_last, spec_win(5)); end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] f2_first;
    int v;
    clear_stats();
    f2_first = '0;
    for (int i = 0; i < 32; i++) begin
      v = (i < 16) ? i : 100 + (i - 16);
      step(1'b1, 1'b0, px(v, v + 50));
      if (i == 26) f2_first = ot_fmap_o;
      checks++;
      if (ot_valid_o !== exp_valid || ot_frame_done_o !== exp_done || ot_fmap_o !== exp_fmap) begin
        errors++;
        $display("FAIL b2b px%0d got v=%b d=%b f=%h want v=%b d=%b f=%h", i,
                 ot_valid_o, ot_frame_done_o, ot_fmap_o, exp_valid, exp_done, exp_fmap);
      end
    end
    checks++; if (dut_wins != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", dut_wins); end
    checks++; if (dut_dones != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", dut_dones); end
    checks++; if (f2_first !== spec_win(100)) begin errors++; $display("FAIL b2b_f2_first got %h want %h", f2_first, spec_win(100)); end
  endtask

  task automatic test_soft_reset();
    clear_stats();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, px(i, i + 50));
    step(1'b1, 1'b1, px(9, 59));
    checks++;
    if (ot_valid_o !== 1'b0 || ot_frame_done_o !== 1'b0 || ot_fmap_o !== '0) begin
      errors++;
      $display("FAIL srst_clear got v=%b d=%b f=%h want v=0 d=0 f=0", ot_valid_o, ot_frame_done_o, ot_fmap_o);
    end
    clear_stats();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, px(i, i + 50));
      checks++;
      if (ot_valid_o !== exp_valid || ot_frame_done_o !== exp_done || ot_fmap_o !== exp_fmap) begin
        errors++;
        $display("FAIL srst px%0d got v=%b d=%b f=%h want v=%b d=%b f=%h", i,
                 ot_valid_o, ot_frame_done_o, ot_fmap_o, exp_valid, exp_done, exp_fmap);
      end
    end
    checks++; if (dut_wins != 4) begin errors++; $display("FAIL srst_count got %0d want 4", dut_wins); end
    checks++; if (dut_first !== spec_win(0)) begin errors++; $display("FAIL srst_first got %h want %h", dut_first, spec_win(0)); end
  endtask

  task automatic test_async_reset();
    bit seen;
    seen = 1'b0;
    clear_stats();
    for (int i = 0; i < 16 && !seen; i++) begin
      step(1'b1, 1'b0, px(i, i + 50));
      if (ot_valid_o === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL async_wait got no window want window within 16 pixels"); end
    @(negedge clk);
    in_valid_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ot_valid_o !== 1'b0 || ot_frame_done_o !== 1'b0 || ot_fmap_o !== '0) begin
      errors++;
      $display("FAIL async_clear got v=%b d=%b f=%h want v=0 d=0 f=0", ot_valid_o, ot_frame_done_o, ot_fmap_o);
    end
    #1 reset_n = 1'b1;
    m_row = 0; m_col = 0; exp_fmap = '0;
    clear_stats();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, px(i, i + 50));
      checks++;
      if (ot_valid_o !== exp_valid || ot_frame_done_o !== exp_done || ot_fmap_o !== exp_fmap) begin
        errors++;
        $display("FAIL async px%0d got v=%b d=%b f=%h want v=%b d=%b f=%h", i,
                 ot_valid_o, ot_frame_done_o, ot_fmap_o, exp_valid, exp_done, exp_fmap);
      end
    end
    checks++; if (dut_first !== spec_win(0)) begin errors++; $display("FAIL async_first got %h want %h", dut_first, spec_win(0)); end
  endtask

  task automatic test_random();
    bit v, s;
    for (int n = 0; n < 200; n++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 49) == 0);
      step(v, s, PW'($urandom));
      checks++;
      if (ot_valid_o !== exp_valid || ot_frame_done_o !== exp_done || ot_fmap_o !== exp_fmap) begin
        errors++;
        $display("FAIL random n%0d got v=%b d=%b f=%h want v=%b d=%b f=%h", n,
                 ot_valid_o, ot_frame_done_o, ot_fmap_o, exp_valid, exp_done, exp_fmap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gaps();
    test_back_to_back();
    test_soft_reset();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
